// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the line-refill memory port arbiter.
package mem_bus_pkg;

  localparam int ADDR_W_DFLT   = 32;
  localparam int LINE_W_DFLT   = 128;
  localparam int LINE_OFF_BITS = 4;

  // Requester identifiers, also the encoding of the last-grant pointer
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_XFER = 2'd1,
    D_XFER = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_req_latch.sv
// Per-requester request capture: turns a one-cycle request pulse into a
// pending request that is held (with its address, direction and write data)
// until the arbiter grants it or a flush cancels it. A flush arriving with a
// new pulse replaces the old request with the new one.
module arb_req_latch
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int LINE_W = LINE_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] wdata_i,
  input  logic              flush_i,
  input  logic              active_i,
  input  logic              grant_i,
  output logic              req_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [LINE_W-1:0] wdata_o
);

  logic              pending_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [LINE_W-1:0] wdata_r;
  logic              accept_s;

  // A pulse is taken when this side is free, or when a flush makes room for it
  always_comb begin
    accept_s = valid_req_i & ((~pending_r & ~active_i) | flush_i);
  end

  // Present the request to the arbiter, bypassing the hold register on the pulse cycle
  always_comb begin
    req_o = (pending_r & ~flush_i) | accept_s;
    if (accept_s) begin
      we_o    = we_i;
      addr_o  = addr_i;
      wdata_o = wdata_i;
    end else begin
      we_o    = we_r;
      addr_o  = addr_r;
      wdata_o = wdata_r;
    end
  end

  // Pending flag: cleared on grant or flush, set on an accepted pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 1'b0;
    end else if (grant_i) begin
      pending_r <= 1'b0;
    end else if (accept_s) begin
      pending_r <= 1'b1;
    end else if (flush_i) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_r;
    end
  end

  // Request payload hold register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {LINE_W{1'b0}};
    end else if (accept_s) begin
      we_r    <= we_i;
      addr_r  <= addr_i;
      wdata_r <= wdata_i;
    end else begin
      we_r    <= we_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter for the single 128-bit line-refill memory port shared by the
// I-cache (refills) and D-cache (line reads / writebacks). Grants one
// requester at a time, holds req until ack, returns a one-cycle ready pulse.
// Optional build macro BUS_ARB_RR_EN: round-robin between the two sides on
// simultaneous requests; otherwise D has fixed priority over I.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int LINE_W = LINE_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic              i_flush_i,
  output logic              i_ready_o,
  output logic [LINE_W-1:0] i_data_o,
  input  logic              d_valid_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [LINE_W-1:0] d_wdata_i,
  output logic              d_ready_o,
  output logic [LINE_W-1:0] d_data_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << LINE_OFF_BITS;

  arb_state_e        state_r, state_nx_s;
  logic              i_req_s, d_req_s, i_we_s, d_we_s;
  logic [ADDR_W-1:0] i_addr_s, d_addr_s;
  logic [LINE_W-1:0] i_wdata_s, d_wdata_s;
  logic              grant_i_s, grant_d_s;
  logic              discard_r, discard_nx_s;
  logic              mem_req_r, mem_we_r, i_ready_r, d_ready_r, busy_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [LINE_W-1:0] mem_wdata_r, i_data_r, d_data_r;
  logic              mem_req_nx_s, mem_we_nx_s, i_ready_nx_s, d_ready_nx_s;
  logic [ADDR_W-1:0] mem_addr_nx_s;
  logic [LINE_W-1:0] mem_wdata_nx_s, i_data_nx_s, d_data_nx_s;

  arb_req_latch #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_i_latch (
    .clk(clk), .rst_n(rst_n),
    .valid_req_i(i_valid_req_i), .we_i(1'b0), .addr_i(i_addr_i),
    .wdata_i({LINE_W{1'b0}}), .flush_i(i_flush_i),
    .active_i(state_r == I_XFER), .grant_i(grant_i_s),
    .req_o(i_req_s), .we_o(i_we_s), .addr_o(i_addr_s), .wdata_o(i_wdata_s)
  );

  arb_req_latch #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_d_latch (
    .clk(clk), .rst_n(rst_n),
    .valid_req_i(d_valid_req_i), .we_i(d_we_i), .addr_i(d_addr_i),
    .wdata_i(d_wdata_i), .flush_i(1'b0),
    .active_i(state_r == D_XFER), .grant_i(grant_d_s),
    .req_o(d_req_s), .we_o(d_we_s), .addr_o(d_addr_s), .wdata_o(d_wdata_s)
  );

`ifdef BUS_ARB_RR_EN
  logic last_grant_r;

  // Remember which side won the most recent grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= REQ_I;
    end else if (grant_d_s) begin
      last_grant_r <= REQ_D;
    end else if (grant_i_s) begin
      last_grant_r <= REQ_I;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Round-robin grant: on a tie the side not granted last wins
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (state_r == IDLE) begin
      if (i_req_s && d_req_s) begin
        grant_i_s = (last_grant_r == REQ_D);
        grant_d_s = (last_grant_r != REQ_D);
      end else begin
        grant_i_s = i_req_s;
        grant_d_s = d_req_s;
      end
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end
`else
  // Fixed-priority grant: D over I, only while idle
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (state_r == IDLE) begin
      grant_d_s = d_req_s;
      grant_i_s = i_req_s & ~d_req_s;
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state: enter a transfer on grant, return to idle on memory ack
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_d_s) begin
          state_nx_s = D_XFER;
        end else if (grant_i_s) begin
          state_nx_s = I_XFER;
        end else begin
          state_nx_s = IDLE;
        end
      end
      I_XFER, D_XFER: begin
        if (mem_ack_i) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = state_r;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and the I-side discard flag
  always_comb begin
    mem_req_nx_s   = mem_req_r;
    mem_we_nx_s    = mem_we_r;
    mem_addr_nx_s  = mem_addr_r;
    mem_wdata_nx_s = mem_wdata_r;
    i_ready_nx_s   = 1'b0;
    d_ready_nx_s   = 1'b0;
    i_data_nx_s    = i_data_r;
    d_data_nx_s    = d_data_r;
    discard_nx_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_d_s) begin
          mem_req_nx_s   = 1'b1;
          mem_we_nx_s    = d_we_s;
          mem_addr_nx_s  = d_addr_s & LINE_MASK;
          mem_wdata_nx_s = d_wdata_s;
        end else if (grant_i_s) begin
          mem_req_nx_s   = 1'b1;
          mem_we_nx_s    = i_we_s;
          mem_addr_nx_s  = i_addr_s & LINE_MASK;
          mem_wdata_nx_s = i_wdata_s;
        end else begin
          mem_req_nx_s   = 1'b0;
        end
      end
      I_XFER: begin
        if (mem_ack_i) begin
          mem_req_nx_s = 1'b0;
          // A flush during the transfer (even on the ack cycle) suppresses delivery
          if (!(discard_r || i_flush_i)) begin
            i_ready_nx_s = 1'b1;
            i_data_nx_s  = mem_rdata_i;
          end else begin
            i_ready_nx_s = 1'b0;
          end
        end else begin
          discard_nx_s = discard_r | i_flush_i;
        end
      end
      D_XFER: begin
        if (mem_ack_i) begin
          mem_req_nx_s = 1'b0;
          d_ready_nx_s = 1'b1;
          d_data_nx_s  = mem_we_r ? {LINE_W{1'b0}} : mem_rdata_i;
        end else begin
          d_ready_nx_s = 1'b0;
        end
      end
      default: mem_req_nx_s = 1'b0;
    endcase
  end

  // Output and discard-flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {LINE_W{1'b0}};
      i_ready_r   <= 1'b0;
      d_ready_r   <= 1'b0;
      i_data_r    <= {LINE_W{1'b0}};
      d_data_r    <= {LINE_W{1'b0}};
      busy_r      <= 1'b0;
      discard_r   <= 1'b0;
    end else begin
      mem_req_r   <= mem_req_nx_s;
      mem_we_r    <= mem_we_nx_s;
      mem_addr_r  <= mem_addr_nx_s;
      mem_wdata_r <= mem_wdata_nx_s;
      i_ready_r   <= i_ready_nx_s;
      d_ready_r   <= d_ready_nx_s;
      i_data_r    <= i_data_nx_s;
      d_data_r    <= d_data_nx_s;
      busy_r      <= (state_nx_s != IDLE);
      discard_r   <= discard_nx_s;
    end
  end

  assign mem_req_o   = mem_req_r;
  assign mem_we_o    = mem_we_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_wdata_o = mem_wdata_r;
  assign i_ready_o   = i_ready_r;
  assign d_ready_o   = d_ready_r;
  assign i_data_o    = i_data_r;
  assign d_data_o    = d_data_r;
  assign busy_o      = busy_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// random legal traffic, all checked cycle by cycle against a transaction-level
// model of the arbitration rules kept in this file.
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;
`ifdef BUS_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid_req_i, i_flush_i, d_valid_req_i, d_we_i, mem_ack_i;
  logic [AW-1:0] i_addr_i, d_addr_i;
  logic [LW-1:0] d_wdata_i, mem_rdata_i;
  logic          i_ready_o, d_ready_o, mem_req_o, mem_we_o, busy_o;
  logic [LW-1:0] i_data_o, d_data_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid_req_i(i_valid_req_i), .i_addr_i(i_addr_i), .i_flush_i(i_flush_i),
    .i_ready_o(i_ready_o), .i_data_o(i_data_o),
    .d_valid_req_i(d_valid_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_ready_o(d_ready_o), .d_data_o(d_data_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending requests, the transfer in progress, expected outputs
  logic          m_pi, m_pd, m_pd_we, m_disc, m_last_d;
  logic [AW-1:0] m_pi_addr, m_pd_addr;
  logic [LW-1:0] m_pd_wd;
  int            m_own;   // 0 none, 1 I-side transfer, 2 D-side transfer
  int            m_wait, m_lat;
  logic          exp_mem_req, exp_mem_we, exp_i_ready, exp_d_ready;
  logic [AW-1:0] exp_mem_addr;
  logic [LW-1:0] exp_mem_wdata, exp_i_data, exp_d_data;

  // Bench knobs
  int lat_cfg = 1;
  bit lat_rand = 1'b0;
  bit stray_ack = 1'b0;
  bit rdata_rand = 1'b1;
  int i_ready_seen = 0;

  localparam logic [LW-1:0] DEADBEEF = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [LW-1:0] A5LINE   = {16{8'hA5}};

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pi = 1'b0; m_pd = 1'b0; m_pd_we = 1'b0; m_disc = 1'b0; m_last_d = 1'b0;
    m_pi_addr = '0; m_pd_addr = '0; m_pd_wd = '0;
    m_own = 0; m_wait = 0; m_lat = 0;
    exp_mem_req = 1'b0; exp_mem_we = 1'b0; exp_i_ready = 1'b0; exp_d_ready = 1'b0;
    exp_mem_addr = '0; exp_mem_wdata = '0; exp_i_data = '0; exp_d_data = '0;
  endtask

  // One clock edge of the arbitration rules, using the inputs being applied
  task automatic model_edge();
    logic pick_d;
    exp_i_ready = 1'b0;
    exp_d_ready = 1'b0;
    if (i_valid_req_i && ((!m_pi && m_own != 1) || i_flush_i)) begin
      m_pi = 1'b1; m_pi_addr = i_addr_i;
    end else if (i_flush_i) begin
      m_pi = 1'b0;
    end
    if (d_valid_req_i && !m_pd && m_own != 2) begin
      m_pd = 1'b1; m_pd_we = d_we_i; m_pd_addr = d_addr_i; m_pd_wd = d_wdata_i;
    end
    if (m_own == 0) begin
      if (m_pi || m_pd) begin
        pick_d = m_pd && (!m_pi || !RR || !m_last_d);
        exp_mem_req = 1'b1;
        if (pick_d) begin
          m_own = 2; exp_mem_we = m_pd_we; exp_mem_addr = m_pd_addr & 32'hFFFF_FFF0;
          exp_mem_wdata = m_pd_wd; m_pd = 1'b0; m_last_d = 1'b1;
        end else begin
          m_own = 1; exp_mem_we = 1'b0; exp_mem_addr = m_pi_addr & 32'hFFFF_FFF0;
          exp_mem_wdata = '0; m_pi = 1'b0; m_last_d = 1'b0;
        end
        m_disc = 1'b0; m_wait = 0;
        m_lat = lat_rand ? int'($urandom_range(0, 3)) : lat_cfg;
      end
    end else begin
      if (m_own == 1 && i_flush_i) m_disc = 1'b1;
      if (mem_ack_i) begin
        if (m_own == 1) begin
          if (!m_disc) begin exp_i_ready = 1'b1; exp_i_data = mem_rdata_i; end
        end else begin
          exp_d_ready = 1'b1; exp_d_data = exp_mem_we ? '0 : mem_rdata_i;
        end
        exp_mem_req = 1'b0; m_own = 0;
      end else begin
        m_wait++;
      end
    end
  endtask

  task automatic check_outputs();
    chk("mem_req", LW'(mem_req_o), LW'(exp_mem_req));
    chk("mem_we", LW'(mem_we_o), LW'(exp_mem_we));
    chk("mem_addr", LW'(mem_addr_o), LW'(exp_mem_addr));
    chk("mem_wdata", mem_wdata_o, exp_mem_wdata);
    chk("i_ready", LW'(i_ready_o), LW'(exp_i_ready));
    chk("i_data", i_data_o, exp_i_data);
    chk("d_ready", LW'(d_ready_o), LW'(exp_d_ready));
    chk("d_data", d_data_o, exp_d_data);
    chk("busy", LW'(busy_o), LW'(m_own != 0));
  endtask

  // Called at a falling edge with request inputs set; memory side is driven here
  task automatic step();
    if (m_own != 0) mem_ack_i = (m_wait >= m_lat);
    else            mem_ack_i = stray_ack && ($urandom_range(0, 5) == 0);
    if (rdata_rand) mem_rdata_i = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    if (i_ready_o === 1'b1) i_ready_seen++;
    @(negedge clk);
    i_valid_req_i = 1'b0; i_flush_i = 1'b0; d_valid_req_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst_n = 1'b0;
    i_valid_req_i = 1'b0; i_flush_i = 1'b0; d_valid_req_i = 1'b0; d_we_i = 1'b0;
    mem_ack_i = 1'b0; i_addr_i = '0; d_addr_i = '0; d_wdata_i = '0; mem_rdata_i = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // 1: I refill, ack 3 cycles after req rises
    lat_cfg = 3; rdata_rand = 1'b0; mem_rdata_i = DEADBEEF;
    i_valid_req_i = 1'b1; i_addr_i = 32'h0000_1234;
    step();
    chk("t1_addr", LW'(mem_addr_o), LW'(32'h0000_1230));
    run(3);
    chk("t1_req_c4", LW'(mem_req_o), LW'(1'b1));
    step();
    chk("t1_ready", LW'(i_ready_o), LW'(1'b1));
    chk("t1_data", i_data_o, DEADBEEF);
    step();
    chk("t1_ready_once", LW'(i_ready_o), LW'(1'b0));
    rdata_rand = 1'b1;

    // 3: D writeback, held until ack, d_data 0
    lat_cfg = 2;
    d_valid_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h8000_0040; d_wdata_i = A5LINE;
    step();
    chk("t3_we", LW'(mem_we_o), LW'(1'b1));
    run(2);
    chk("t3_wdata_held", mem_wdata_o, A5LINE);
    step();
    chk("t3_ready", LW'(d_ready_o), LW'(1'b1));
    chk("t3_data_zero", d_data_o, '0);
    run(2);

    // 2: simultaneous I and D reads, last grant was D
    lat_cfg = 1;
    i_valid_req_i = 1'b1; i_addr_i = 32'h0000_2000;
    d_valid_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_3000;
    step();
    chk("t2_first_grant", LW'(mem_addr_o), LW'(RR ? 32'h0000_2000 : 32'h0000_3000));
    run(8);

    // 4: flush with a new I pulse while an I refill is in flight
    lat_cfg = 4; i_ready_seen = 0;
    i_valid_req_i = 1'b1; i_addr_i = 32'h0000_4444;
    run(2);
    i_flush_i = 1'b1; i_valid_req_i = 1'b1; i_addr_i = 32'h0000_5558;
    step();
    run(12);
    chk("t4_iready_count", LW'(i_ready_seen), LW'(1));

    // 5: flush while D in flight and I pending
    lat_cfg = 3; i_ready_seen = 0;
    d_valid_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_6000;
    step();
    i_valid_req_i = 1'b1; i_addr_i = 32'h0000_7000;
    step();
    i_flush_i = 1'b1;
    step();
    run(6);
    chk("t5_iready_count", LW'(i_ready_seen), LW'(0));
    chk("t5_req_low", LW'(mem_req_o), LW'(1'b0));

    // 6: asynchronous reset mid-transfer, then a fresh request
    lat_cfg = 5;
    i_valid_req_i = 1'b1; i_addr_i = 32'h0000_9ABC;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_req", LW'(mem_req_o), LW'(1'b0));
    chk("t6_rst_busy", LW'(busy_o), LW'(1'b0));
    chk("t6_rst_addr", LW'(mem_addr_o), '0);
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    lat_cfg = 2; i_ready_seen = 0;
    i_valid_req_i = 1'b1; i_addr_i = 32'h0000_9ABC;
    step();
    chk("t6_addr", LW'(mem_addr_o), LW'(32'h0000_9AB0));
    run(5);
    chk("t6_iready_count", LW'(i_ready_seen), LW'(1));

    // Random legal traffic
    lat_rand = 1'b1; stray_ack = 1'b1;
    for (int c = 0; c < 500; c++) begin
      i_flush_i     = ($urandom_range(0, 7) == 0);
      i_valid_req_i = (((!m_pi) && (m_own != 1)) || i_flush_i) && ($urandom_range(0, 2) == 0);
      i_addr_i      = $urandom();
      d_valid_req_i = (!m_pd) && (m_own != 2) && ($urandom_range(0, 2) == 0);
      d_we_i        = $urandom_range(0, 1) == 1;
      d_addr_i      = $urandom();
      d_wdata_i     = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
    end
    stray_ack = 1'b0;
    run(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Sequences the single 128-bit line-refill memory port between instruction-cache refills and data-cache line reads/writebacks. Each requester issues a one-cycle request pulse with a line-aligned address. The arbiter latches the pulse, grants the port and holds a req/ack handshake toward memory, then returns a one-cycle ready pulse with the line to the owner. It sits between the two caches and the external memory/bus model, and supports flushing a stale I-side refill on a control-flow redirect.

Parameters:
ADDR_W, 32, address width (line-aligned, low 4 bits forced to 0 on mem_addr_o)
LINE_W, 128, cache line / memory data width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
i_valid_req_i  in  1  I-side request pulse (one cycle)
i_addr_i  in  ADDR_W  I-side line address
i_flush_i  in  1  I-side redirect; cancels outstanding I refill
i_ready_o  out  1  I-side completion pulse
i_data_o  out  LINE_W  I-side refill line, valid with i_ready_o
d_valid_req_i  in  1  D-side request pulse (one cycle)
d_we_i  in  1  D-side 1=writeback line, 0=read line
d_addr_i  in  ADDR_W  D-side line address
d_wdata_i  in  LINE_W  D-side writeback data
d_ready_o  out  1  D-side completion pulse
d_data_o  out  LINE_W  D-side read line, valid with d_ready_o (0 for writes)
mem_req_o  out  1  memory request, held until ack
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory line address
mem_wdata_o  out  LINE_W  memory write data
mem_ack_i  in  1  memory completion (one cycle); rdata valid same cycle
mem_rdata_i  in  LINE_W  memory read line
busy_o  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; pending flags, discard flag and priority pointer cleared. Reset asserted mid-transfer drops mem_req_o immediately (async) and loses the transfer; no ready pulse is issued.
- Per-requester pending register: captures addr/we/wdata on the pulse edge. A pulse while that side is already pending or in transfer is a protocol violation: the pulse is ignored and the bench flags it.
- States: IDLE, I_XFER, D_XFER.
- IDLE: requests are the pending flags OR the same-cycle pulse. If any request is present, grant at the clock edge: state moves to X_XFER and mem_req_o/we/addr/wdata are registered. A pulse in cycle 0 with the arbiter idle gives mem_req_o=1 in cycle 1.
- Fixed priority (default): D over I.
- X_XFER: mem_req_o and all mem_* outputs are held stable until mem_ack_i. On ack in cycle k:
  - x_ready_o=1 and x_data_o=mem_rdata_i (registered) in cycle k+1.
  - mem_req_o=0 in cycle k+1; state returns to IDLE in cycle k+1.
  - The next grant occurs no earlier than the k+1 edge, so mem_req_o is high again in cycle k+2 at the earliest.
- Ready pulses last exactly one cycle. Data outputs hold their last value otherwise.
- i_flush_i behaviour:
  - I pending, not granted: pending is cleared.
  - I_XFER: the discard flag is set; the transfer completes on the memory side, then no i_ready_o pulse is issued. Discard clears on return to IDLE.
  - Flush in the same cycle as i_valid_req_i: the new request is kept (it is the redirect target) and the old one is dropped. If in I_XFER, the old transfer is still discarded and the new one is pending.
  - Flush has no effect on the D side.
- Simultaneous I and D requests in IDLE: D granted; I stays pending and is granted next.
- mem_ack_i outside X_XFER: ignored.

Optional Feature:
BUS_ARB_RR_EN
- Defined: round-robin arbitration. A one-bit last-grant pointer is updated on each grant; on simultaneous requests the side not granted last wins. This bounds I-side starvation to one D transfer.
- Undefined: fixed D-over-I priority; the pointer logic is absent.

Decomposition:
- Package mem_bus_pkg:
  - state enum (IDLE, I_XFER, D_XFER)
  - LINE_W/ADDR_W defaults
  - LINE_OFF_BITS=4
  - requester ID constants (REQ_I=0, REQ_D=1)
- Sub-module arb_req_latch, instantiated twice: pulse capture, pending flag, addr/we/wdata hold, clear-on-grant, clear-on-flush (flush input tied 0 for D).

Test Plan:
1. I pulse addr 0x0000_1234 in cycle 0, memory acks 3 cycles after req rises with rdata=0xDEAD…BEEF -> mem_req_o high cycles 1–4, mem_addr_o=0x0000_1230, i_ready_o=1 for one cycle in cycle 5, i_data_o=0xDEAD…BEEF.
2. I and D read pulses in the same cycle -> D granted first, I granted second, with mem_req_o low for exactly one cycle between transfers. With BUS_ARB_RR_EN and last grant=D, I is granted first.
3. D writeback addr 0x8000_0040, wdata pattern 0xA5…A5 -> mem_we_o=1 and mem_wdata_o held until ack; d_ready_o pulses with d_data_o=0.
4. I transfer in flight, i_flush_i pulsed before ack -> no i_ready_o for that transfer; busy_o drops after ack. A new I pulse with the flush is serviced next with the correct address.
5. D transfer in flight with I pending, i_flush_i pulsed -> I pending cleared, only d_ready_o occurs, and mem_req_o is not re-raised.
6. rst_n asserted while mem_req_o=1 -> all outputs 0 asynchronously. After release, a fresh I request completes normally.
